// File: rtl/seq_detector_core_if.sv
// CPU-side command/stream bus of the sequence detector plus its result/status outputs.
// The master drives the command fields; the slave (detector core) drives the results.
interface seq_detector_core_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data_in;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic              out_valid;
  logic              pat_loaded;

  modport master (
    output in_valid, mode, data_in,
    input  match, match_cnt, out_valid, pat_loaded
  );

  modport slave (
    input  in_valid, mode, data_in,
    output match, match_cnt, out_valid, pat_loaded
  );
endinterface

// File: rtl/seq_detector_core.sv
// Pattern loader and overlapping/non-overlapping nibble-stream matcher with saturating count.
// Optional macro SEQ_WILDCARD_EN: an all-ones pattern nibble matches any stream nibble.
module seq_detector_core #(
  parameter int DATA_W  = 4,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  seq_detector_core_if.slave  bus
);
  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] FULL = IDX_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DETECT} state_e;

  state_e                          state_q, state_d;
  logic [PAT_LEN-1:0][DATA_W-1:0]  shadow_q, shadow_d;
  logic [PAT_LEN-1:0][DATA_W-1:0]  pattern_q, pattern_d;
  logic [PAT_LEN-2:0][DATA_W-1:0]  hist_q, hist_d, hist_shift;
  logic [IDX_W-1:0]                load_idx_q, load_idx_d;
  logic [IDX_W-1:0]                hist_cnt_q, hist_cnt_d;
  logic                            overlap_q, overlap_d;
  logic                            pat_loaded_q, pat_loaded_d;
  logic                            match_q, match_d;
  logic                            out_valid_q, out_valid_d;
  logic [CNT_W-1:0]                match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]                cnt_inc;
  logic [PAT_LEN-1:0]              pos_hit;
  logic                            window_hit;

  // Window position 0 is the oldest nibble and lines up with the first loaded pattern nibble.
  for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_cmp
    logic [DATA_W-1:0] win;
    if (gi == PAT_LEN - 1) begin : g_new
      assign win = bus.data_in;
    end else begin : g_old
      assign win = hist_q[PAT_LEN-2-gi];
    end
`ifdef SEQ_WILDCARD_EN
    assign pos_hit[gi] = (pattern_q[gi] == {DATA_W{1'b1}}) || (pattern_q[gi] == win);
`else
    assign pos_hit[gi] = (pattern_q[gi] == win);
`endif
  end

  for (genvar gi = 0; gi < PAT_LEN - 1; gi++) begin : g_shift
    if (gi == 0) begin : g_head
      assign hist_shift[gi] = bus.data_in;
    end else begin : g_tail
      assign hist_shift[gi] = hist_q[gi-1];
    end
  end

  assign window_hit = (&pos_hit) && pat_loaded_q && (hist_cnt_q == FULL);
  assign cnt_inc    = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pattern_d    = pattern_q;
    hist_d       = hist_q;
    load_idx_d   = load_idx_q;
    hist_cnt_d   = hist_cnt_q;
    overlap_d    = overlap_q;
    pat_loaded_d = pat_loaded_q;
    match_d      = 1'b0;
    out_valid_d  = 1'b0;
    match_cnt_d  = match_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          unique case (bus.mode)
            2'd0: begin
              shadow_d[0] = bus.data_in;
              load_idx_d  = IDX_W'(1);
              state_d     = ST_LOAD;
            end
            2'd1, 2'd2: begin
              overlap_d   = (bus.mode == 2'd2);
              hist_d      = hist_shift;
              hist_cnt_d  = IDX_W'(1);
              match_cnt_d = '0;
              state_d     = ST_DETECT;
            end
            default: match_cnt_d = '0;
          endcase
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          shadow_d[load_idx_q] = bus.data_in;
          if (load_idx_q == FULL) begin
            pattern_d    = shadow_d;
            pat_loaded_d = 1'b1;
            load_idx_d   = '0;
            state_d      = ST_IDLE;
          end else begin
            load_idx_d = load_idx_q + IDX_W'(1);
          end
        end else begin
          // Aborted load: the previously held pattern stays valid.
          load_idx_d = '0;
          state_d    = ST_IDLE;
        end
      end
      ST_DETECT: begin
        if (bus.in_valid) begin
          hist_d = hist_shift;
          if (window_hit) begin
            match_d     = 1'b1;
            match_cnt_d = cnt_inc;
            hist_cnt_d  = overlap_q ? hist_cnt_q : '0;
          end else if (hist_cnt_q != FULL) begin
            hist_cnt_d = hist_cnt_q + IDX_W'(1);
          end
        end else begin
          out_valid_d = 1'b1;
          hist_cnt_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      pattern_q    <= '0;
      hist_q       <= '0;
      load_idx_q   <= '0;
      hist_cnt_q   <= '0;
      overlap_q    <= 1'b0;
      pat_loaded_q <= 1'b0;
      match_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pattern_q    <= pattern_d;
      hist_q       <= hist_d;
      load_idx_q   <= load_idx_d;
      hist_cnt_q   <= hist_cnt_d;
      overlap_q    <= overlap_d;
      pat_loaded_q <= pat_loaded_d;
      match_q      <= match_d;
      out_valid_q  <= out_valid_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign bus.match      = match_q;
  assign bus.match_cnt  = match_cnt_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.pat_loaded = pat_loaded_q;
endmodule
